// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: user-side data/control and active-low display pins of the scanner
interface seg7_scan_display_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0] dp_in, digit_en, an;
  logic load, lz_en, dp;
  logic [6:0] seg;
  modport master(output data, dp_in, digit_en, load, lz_en, input seg, dp, an);
  modport slave(input data, dp_in, digit_en, load, lz_en, output seg, dp, an);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed hex seven-segment scanner with blanking, dp and leading-zero suppression
module seg7_scan_display #(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_display_if.slave bus
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  if (DIGITS < 1 || DIGITS > 8 || REFRESH_DIV <= BLANK_CYCLES) begin : g_bad_params
    $error("seg7_scan_display: illegal DIGITS/REFRESH_DIV/BLANK_CYCLES");
  end
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0] dps_q, dps_d, an_q, an_d, hz;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] nib;
  logic dp_q, dp_d, z, on, sup;
  // hz[k]: nibbles DIGITS-1..k are all zero
  always_comb begin
    z = 1'b1;
    hz = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z = z & (data_q[4*k +: 4] == 4'h0);
      hz[k] = z;
    end
  end
  always_comb begin
    data_d = bus.load ? bus.data : data_q;
    dps_d = bus.load ? bus.dp_in : dps_q;
    cnt_d = cnt_q == CW'(REFRESH_DIV - 1) ? '0 : cnt_q + 1'b1;
    idx_d = cnt_q != CW'(REFRESH_DIV - 1) ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    nib = data_q[4*idx_q +: 4];
    on = cnt_q >= CW'(BLANK_CYCLES) && bus.digit_en[idx_q];
    sup = bus.lz_en && idx_q != '0 && hz[idx_q];
    seg_d = on && !sup ? ~HEX[7*nib +: 7] : 7'h7F;
    dp_d = on ? ~dps_q[idx_q] : 1'b1;
    an_d = on ? ~(DIGITS'(1) << idx_q) : '1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dps_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      dp_q <= 1'b1;
      an_q <= '1;
    end else begin
      data_q <= data_d;
      dps_q <= dps_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.an = an_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: scoreboard bench; expected {an,seg,dp} queued per cycle, monitor compares at negedge
module tb_seg7_scan_display;
  typedef struct {
    int k;
    int tag;
    logic [11:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int cyc;
  int n_tests = 0;
  int n_fail = 0;
  exp_t q[$];
  exp_t me;
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [27:0] SG1234 = {~7'h06, ~7'h5B, ~7'h4F, ~7'h66};
  localparam logic [27:0] SGABCD = {~7'h77, ~7'h7C, ~7'h39, ~7'h5E};
  localparam logic [27:0] SGZERO = {~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F};
  seg7_scan_display_if #(.DIGITS(4)) bus ();
  seg7_scan_display #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end
  task automatic chk(int tag, string nm, logic [11:0] act, logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL scn%0d %s cyc=%0d: got {an,seg,dp}=%h, want %h", tag, nm, cyc, act, exp);
    end
  endtask
  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1 chk(0, "reset", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
    end else if (flush) begin
      chk(0, "drain_timeout", 12'(q.size()), 12'd0);
      q.delete();
    end else begin
      while (q.size() > 0 && q[0].k <= cyc) begin
        me = q.pop_front();
        if (me.k < cyc) chk(me.tag, "missed", 12'(cyc), 12'(me.k));
        else chk(me.tag, "scan", {bus.an, bus.seg, bus.dp}, me.v);
      end
    end
  end
  // output after the k-th edge reflects scan state k-1 (slot = (k-1)/8, position = (k-1)%8)
  task automatic push_scan(int tag, int k0, int n, logic [27:0] sg, logic [3:0] dpv, logic [3:0] en);
    for (int k = k0; k < k0 + n; k++) begin
      int s;
      int i;
      logic lit;
      exp_t e;
      s = k - 1;
      i = (s / 8) % 4;
      lit = (s % 8 >= 2) && en[i];
      e.k = k;
      e.tag = tag;
      e.v = lit ? {~(4'b1 << i), sg[7*i +: 7], ~dpv[i]} : {4'hF, 7'h7F, 1'b1};
      q.push_back(e);
    end
  endtask
  task automatic begin_scn(logic [15:0] d, logic [3:0] dpv, logic [3:0] en, logic lz);
    rst_n = 1'b0;
    bus.data = d;
    bus.dp_in = dpv;
    bus.digit_en = en;
    bus.lz_en = lz;
    bus.load = 1'b1;
    @(negedge clk);
  endtask
  task automatic go();
    rst_n = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (q.size() > 0) begin
      flush = 1'b1;
      @(negedge clk);
      #1 flush = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.data = '0;
    bus.dp_in = '0;
    bus.digit_en = '0;
    bus.lz_en = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    begin_scn(16'h1234, 4'h0, 4'hF, 1'b0);
    push_scan(1, 1, 40, SG1234, 4'h0, 4'hF);
    go();
    drain();
    for (int v = 0; v < 16; v++) begin
      begin_scn({12'h000, 4'(v)}, 4'h0, 4'b0001, 1'b0);
      push_scan(20 + v, 1, 10, {21'h1FFFFF, ~pat[v]}, 4'h0, 4'b0001);
      go();
      drain();
    end
    begin_scn(16'h0050, 4'h0, 4'hF, 1'b1);
    push_scan(3, 1, 40, {7'h7F, 7'h7F, ~7'h6D, ~7'h3F}, 4'h0, 4'hF);
    go();
    drain();
    begin_scn(16'h0000, 4'h0, 4'hF, 1'b1);
    push_scan(4, 1, 40, {7'h7F, 7'h7F, 7'h7F, ~7'h3F}, 4'h0, 4'hF);
    go();
    drain();
    begin_scn(16'h1234, 4'b0100, 4'b1011, 1'b0);
    push_scan(5, 1, 40, SG1234, 4'b0100, 4'b1011);
    go();
    drain();
    begin_scn(16'h1234, 4'b1001, 4'hF, 1'b0);
    push_scan(6, 1, 40, SG1234, 4'b1001, 4'hF);
    go();
    drain();
    begin_scn(16'h1234, 4'h0, 4'hF, 1'b0);
    push_scan(7, 1, 16, SG1234, 4'h0, 4'hF);
    push_scan(8, 17, 33, SGABCD, 4'h0, 4'hF);
    go();
    repeat (14) @(posedge clk);
    #1;
    bus.data = 16'hABCD;
    bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.data = 16'h5555;
    drain();
    begin_scn(16'h1234, 4'h0, 4'hF, 1'b0);
    push_scan(9, 1, 20, SG1234, 4'h0, 4'hF);
    go();
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    push_scan(10, 1, 12, SGZERO, 4'h0, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
